// File: rtl/pipe_defs.sv
// Shared handshake-pipeline definitions: default payload width and push/pop event naming.
package pipe_defs;

    localparam int PIPE_DATA_W = 3;

    // One handshake completes on the rising edge where its event bit is high.
    typedef struct packed {
        logic push;  // valid_up && ready_up
        logic pop;   // valid_down && ready_down
    } hs_evt_t;

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x DATA_W register array: one synchronous write port, one asynchronous read port.
module fifo_mem #(
    parameter int DATA_W = 3,
    parameter int DEPTH  = 4,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              sys_clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DEPTH-1:0][DATA_W-1:0] mem;

    // Entries are cleared on reset so data_down reads 0 out of reset.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            mem <= '0;
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/pipe_fifo.sv
// First-word-fall-through valid/ready FIFO; all handshake outputs decode registered state only.
module pipe_fifo
    import pipe_defs::*;
#(
    parameter int DATA_W = PIPE_DATA_W,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              sys_clk,
    input  logic              rst_n,
    input  logic              valid_up,
    input  logic [DATA_W-1:0] data_up,
    output logic              ready_up,
    output logic              valid_down,
    output logic [DATA_W-1:0] data_down,
    input  logic              ready_down,
    output logic [CNT_W-1:0]  level,
    output logic              full,
    output logic              empty
);

    localparam int AW = $clog2(DEPTH);

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("pipe_fifo: DEPTH must be a power of two and at least 2");
    end

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    hs_evt_t       ev;

    assign full       = (level == CNT_W'(DEPTH));
    assign empty      = (level == '0);
    assign ready_up   = !full;
    assign valid_down = !empty;

    assign ev.push = valid_up && ready_up;
    assign ev.pop  = valid_down && ready_down;

    // Pointers are exactly log2(DEPTH) bits wide, so wrap needs no extra logic.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (ev.push) wr_ptr <= wr_ptr + 1'b1;
            if (ev.pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({ev.push, ev.pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_mem (
        .sys_clk (sys_clk),
        .rst_n   (rst_n),
        .we      (ev.push),
        .waddr   (wr_ptr),
        .wdata   (data_up),
        .raddr   (rd_ptr),
        .rdata   (data_down)
    );

endmodule

// File: tb/tb_pipe_fifo.sv
// Bench for pipe_fifo: directed scenarios plus random traffic against a queue reference model.
module tb_pipe_fifo;
    import pipe_defs::*;

    localparam int DATA_W = PIPE_DATA_W;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    logic              sys_clk;
    logic              rst_n;
    logic              valid_up;
    logic [DATA_W-1:0] data_up;
    logic              ready_up;
    logic              valid_down;
    logic [DATA_W-1:0] data_down;
    logic              ready_down;
    logic [CNT_W-1:0]  level;
    logic              full;
    logic              empty;

    int n_chk;
    int n_fail;
    int q[$];

    pipe_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .sys_clk    (sys_clk),
        .rst_n      (rst_n),
        .valid_up   (valid_up),
        .data_up    (data_up),
        .ready_up   (ready_up),
        .valid_down (valid_down),
        .data_down  (data_down),
        .ready_down (ready_down),
        .level      (level),
        .full       (full),
        .empty      (empty)
    );

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Compare every output against the queue model.
    task automatic check_outputs(input string tag);
        chk({tag, ".level"},      int'(level),      q.size());
        chk({tag, ".full"},       int'(full),       int'(q.size() == DEPTH));
        chk({tag, ".empty"},      int'(empty),      int'(q.size() == 0));
        chk({tag, ".ready_up"},   int'(ready_up),   int'(q.size() < DEPTH));
        chk({tag, ".valid_down"}, int'(valid_down), int'(q.size() > 0));
        if (q.size() > 0) chk({tag, ".data_down"}, int'(data_down), q[0]);
    endtask

    // One clock: check at negedge, drive inputs, then advance the model at posedge.
    task automatic step(input string tag, input bit vu, input int du, input bit rd);
        bit do_push;
        bit do_pop;
        @(negedge sys_clk);
        check_outputs(tag);
        valid_up   = vu;
        data_up    = DATA_W'(du);
        ready_down = rd;
        do_push = vu && (q.size() < DEPTH);
        do_pop  = rd && (q.size() > 0);
        @(posedge sys_clk);
        if (do_pop)  void'(q.pop_front());
        if (do_push) q.push_back(du % (1 << DATA_W));
    endtask

    // Assert reset away from the clock edge and check the asynchronous reset values.
    task automatic mid_reset(input string tag);
        valid_up   = 1'b0;
        ready_down = 1'b0;
        data_up    = '0;
        #2;
        rst_n = 1'b0;
        #1;
        q.delete();
        check_outputs(tag);
        chk({tag, ".data_down0"}, int'(data_down), 0);
        @(negedge sys_clk);
        rst_n = 1'b1;
    endtask

    initial begin
        n_chk      = 0;
        n_fail     = 0;
        rst_n      = 1'b1;
        valid_up   = 1'b0;
        data_up    = '0;
        ready_down = 1'b0;

        #7;
        mid_reset("rst");

        // Single beat in and out.
        step("single0", 1, 5, 0);
        step("single1", 0, 0, 0);
        step("single2", 0, 0, 1);
        step("single3", 0, 0, 0);
        step("empty_pop", 0, 0, 1);

        // Fill, refuse an extra beat, pop at full, then drain.
        for (int i = 1; i <= 4; i++) step("fill", 1, i, 0);
        step("over", 1, 7, 0);
        step("full_hold", 0, 0, 0);
        step("full_pp", 1, 6, 1);
        step("after_pp", 0, 0, 0);
        for (int i = 0; i < 4; i++) step("drain", 0, 0, 1);
        step("drained", 0, 0, 0);

        // Streaming with downstream always ready: pointers wrap twice.
        for (int i = 0; i < 8; i++) step("stream", 1, i, 1);
        for (int i = 0; i < 2; i++) step("stream_end", 0, 0, 1);

        // Reset with three beats inside, then confirm nothing stale follows.
        for (int i = 0; i < 3; i++) step("pre_rst", 1, i + 4, 0);
        step("pre_rst_chk", 0, 0, 0);
        mid_reset("rst_mid");
        step("post_rst0", 1, 2, 0);
        step("post_rst1", 0, 0, 0);
        step("post_rst2", 0, 0, 1);
        step("post_rst3", 0, 0, 0);

        // Random traffic with phases biased toward filling or draining.
        for (int i = 0; i < 600; i++) begin
            int phase;
            bit vu;
            bit rd;
            phase = (i / 50) % 3;
            vu = (phase == 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            rd = (phase == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 1);
            step("rand", vu, int'($urandom_range(0, (1 << DATA_W) - 1)), rd);
            if ($urandom_range(0, 199) == 0) mid_reset("rand_rst");
        end
        step("final", 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_fifo.md
Name: pipe_fifo

Overview:
- Parameterised valid/ready FIFO stage for the handshake pipeline.
- Sits directly downstream of the ready-registered pipe stage and feeds the slave.
- Absorbs bursts when the slave stalls. Decouples upstream and downstream timing: no combinational path from ready_down to ready_up, and none from valid_up to valid_down.
- First-word-fall-through: the head entry is always presented on data_down.

Parameters:
- DATA_W, 3, width of the data payload in bits.
- DEPTH, 4, number of storage entries. Must be a power of two and at least 2.
- CNT_W, $clog2(DEPTH+1), width of the occupancy count (derived; do not override).

Ports:
- sys_clk  input  1  single clock; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- valid_up  input  1  upstream presents a beat.
- data_up  input  DATA_W  upstream payload.
- ready_up  output  1  FIFO can accept a beat this cycle.
- valid_down  output  1  head entry is valid.
- data_down  output  DATA_W  head entry payload.
- ready_down  input  1  downstream consumes a beat this cycle.
- level  output  CNT_W  current occupancy, 0..DEPTH.
- full  output  1  level == DEPTH.
- empty  output  1  level == 0.

Behaviour:
- Reset (asynchronous assert, synchronous release with sys_clk): wr_ptr=0, rd_ptr=0, level=0, all storage entries=0.
  - Resulting outputs: ready_up=1, valid_down=0, data_down=0, full=0, empty=1.
- Handshake events:
  - push = valid_up && ready_up.
  - pop = valid_down && ready_down.
  - A beat transfers only on the rising edge where its respective handshake is high.
- ready_up = !full. It derives only from registered level; it is never combinational from ready_down.
  - A pop in the same cycle as full does not open ready_up until the next cycle. No full-state bypass.
- valid_down = !empty. data_down = mem[rd_ptr]. Both derive from registered state only.
- Push: mem[wr_ptr] <= data_up; wr_ptr increments modulo DEPTH. Wrap is natural via pointer width log2(DEPTH).
- Pop: rd_ptr increments modulo DEPTH.
- Level update:
  - push only: level+1.
  - pop only: level-1.
  - push and pop together: level unchanged, both pointers advance.
- Latency: a beat pushed into an empty FIFO appears on valid_down/data_down on the next rising edge (1 cycle). There is no same-cycle passthrough.
- Throughput: 1 beat/cycle sustained when 0 < level < DEPTH and both sides are active.
- Stability rule: while valid_down=1 and ready_down=0, data_down and valid_down hold unchanged.
- Upstream side: valid_up/data_up asserted while ready_up=0 are ignored. No storage write, no pointer change.
- Boundary cases:
  - Empty with ready_down=1: no pop, level stays 0. Level never underflows.
  - Full with valid_up=1: no push. Level never exceeds DEPTH.
  - Simultaneous push/pop at level=1: the head is replaced by the new beat on the next cycle; valid_down stays 1.
  - Reset mid-burst: all contents are discarded immediately. Outputs take reset values asynchronously; no partial beat is emitted after release.
- full and empty are combinational decodes of registered level, glitch-free with respect to handshake inputs.

Decomposition:
- Shared package/header pipe_defs:
  - DATA_W default constant (3), shared with the master, pipe stages and slave.
  - Handshake event naming for push/pop.
- One natural sub-module: fifo_mem. A DEPTH x DATA_W register array with write port (we, waddr, wdata), asynchronous read port (raddr, rdata), and async active-low reset clearing entries.
- Pointer/level control lives in pipe_fifo itself.

Test Plan:
- Reset check: assert rst_n=0 mid-clock -> immediately ready_up=1, valid_down=0, data_down=0, level=0, empty=1, full=0.
- Single beat, DEPTH=4: push data_up=3'd5 with ready_down=0 -> next cycle valid_down=1, data_down=5, level=1. Then ready_down=1 for one cycle -> next cycle valid_down=0, level=0.
- Fill and stall: push 1,2,3,4 back-to-back with ready_down=0 -> full=1, ready_up=0, level=4. A fifth beat 3'd7 offered is not stored. Drain -> outputs 1,2,3,4 in order, then empty=1.
- Wrap-around: after the fill/drain, stream 8 beats 0..7 with ready_down held 1 -> all 8 emerge in order with 1-cycle latency. Pointers wrap twice; level never exceeds 1.
- Simultaneous push/pop at full: level=4, valid_up=1, ready_down=1 -> pop occurs, push refused (ready_up=0); next cycle level=3, ready_up=1.
- Reset mid-operation: level=3, assert rst_n=0 -> level=0, valid_down=0 at once. After release, push 3'd2 -> data_down=2; no stale beats appear.
